// File: rtl/kf8237_common_pkg.sv
// kf8237_common_pkg: shared types, reset constant and byte-merge helper for the 8237 address/count register file
package kf8237_common_pkg;
  typedef logic [1:0] channel_t;
  typedef logic [15:0] word_t;
  localparam word_t RESET_WORD_DEFAULT = 16'h0000;
  function automatic word_t write_byte(word_t word, logic [7:0] data, logic high);
    return high ? {data, word[7:0]} : {word[15:8], data};
  endfunction
endpackage

// File: rtl/kf8237_channel_register.sv
// kf8237_channel_register: base/current address and word count of one DMA channel with update and autoinitialize
module kf8237_channel_register
  import kf8237_common_pkg::*;
#(
  parameter word_t RESET_WORD = RESET_WORD_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       byte_pointer,
  input  logic       write_address,
  input  logic       write_count,
  input  logic       update,
  input  logic       decrement,
  input  logic       autoinitialize,
  input  logic       hold,
  output word_t      current_address,
  output word_t      current_count,
  output logic       terminal_count
);
  word_t base_address, base_count, next_address, next_count;
  logic reload;
  always_comb begin
    terminal_count = update && current_count == 16'h0000;
    reload = terminal_count && autoinitialize;
    next_address = !update ? current_address : reload ? base_address : hold ? current_address :
                   decrement ? current_address - 16'd1 : current_address + 16'd1;
    next_count = !update ? current_count : reload ? base_count : current_count - 16'd1;
  end
  // A CPU write overrides only its own byte; the other byte keeps the transfer update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_address <= RESET_WORD;
      base_count <= RESET_WORD;
      current_address <= RESET_WORD;
      current_count <= RESET_WORD;
    end else begin
      base_address <= write_address ? write_byte(base_address, data, byte_pointer) : base_address;
      base_count <= write_count ? write_byte(base_count, data, byte_pointer) : base_count;
      current_address <= write_address ? write_byte(next_address, data, byte_pointer) : next_address;
      current_count <= write_count ? write_byte(next_count, data, byte_pointer) : next_count;
    end
  end
endmodule

// File: rtl/kf8237_address_and_count.sv
// kf8237_address_and_count: 4-channel 8237 address/count registers, byte pointer, read-back and TC pulse.
// Optional KF8237_ADDRESS_HOLD_EN freezes channel 0 address on update while address_hold is set.
module kf8237_address_and_count
  import kf8237_common_pkg::*;
#(
  parameter int    CHANNELS   = 4,
  parameter word_t RESET_WORD = RESET_WORD_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [7:0]          internal_data_bus,
  input  logic [CHANNELS-1:0] write_base_and_current_address,
  input  logic [CHANNELS-1:0] write_base_and_current_word_count,
  input  logic [CHANNELS-1:0] read_current_address,
  input  logic [CHANNELS-1:0] read_current_word_count,
  input  logic                clear_byte_pointer,
  input  logic                set_byte_pointer,
  input  logic                master_clear,
  input  channel_t            dma_select,
  input  logic                update_address,
  input  logic                address_decrement,
  input  logic                autoinitialize,
  input  logic                address_hold,
  output logic [7:0]          read_data,
  output logic                read_data_enable,
  output word_t               current_address,
  output logic                terminal_count,
  output logic                byte_pointer
);
  word_t channel_address [CHANNELS];
  word_t channel_count [CHANNELS];
  logic [CHANNELS-1:0] channel_tc;
  logic read_any, read_any_d, hold, toggle;
`ifdef KF8237_ADDRESS_HOLD_EN
  assign hold = address_hold;
`else
  logic unused_address_hold;
  assign unused_address_hold = address_hold;
  assign hold = 1'b0;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    kf8237_channel_register #(.RESET_WORD(RESET_WORD)) u_channel (
      .clock          (clock),
      .reset_n        (reset_n),
      .data           (internal_data_bus),
      .byte_pointer   (byte_pointer),
      .write_address  (write_base_and_current_address[c]),
      .write_count    (write_base_and_current_word_count[c]),
      .update         (update_address && dma_select == channel_t'(c)),
      .decrement      (address_decrement),
      .autoinitialize (autoinitialize),
      .hold           ((c == 0) ? hold : 1'b0),
      .current_address(channel_address[c]),
      .current_count  (channel_count[c]),
      .terminal_count (channel_tc[c])
    );
  end
  assign read_any = |{read_current_address, read_current_word_count};
  assign read_data_enable = read_any;
  assign current_address = channel_address[dma_select];
  // One toggle per write cycle, or once at the end of a read cycle however long it lasted
  assign toggle = |{write_base_and_current_address, write_base_and_current_word_count} || (read_any_d && !read_any);
  always_comb begin
    read_data = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      read_data |= read_current_address[i] ? (byte_pointer ? channel_address[i][15:8] : channel_address[i][7:0]) : 8'h00;
      read_data |= read_current_word_count[i] ? (byte_pointer ? channel_count[i][15:8] : channel_count[i][7:0]) : 8'h00;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_pointer <= 1'b0;
      terminal_count <= 1'b0;
      read_any_d <= 1'b0;
    end else begin
      read_any_d <= read_any;
      terminal_count <= !master_clear && |channel_tc;
      byte_pointer <= (master_clear || clear_byte_pointer) ? 1'b0 : set_byte_pointer ? 1'b1 :
                      toggle ? ~byte_pointer : byte_pointer;
    end
  end
endmodule

// File: tb/tb_kf8237_address_and_count.sv
// tb_kf8237_address_and_count: scoreboard bench with a word-level reference model, directed plan plus random traffic
module tb_kf8237_address_and_count;
  logic clock = 1'b0;
  logic reset_n;
  logic [7:0] internal_data_bus;
  logic [3:0] write_base_and_current_address, write_base_and_current_word_count;
  logic [3:0] read_current_address, read_current_word_count;
  logic clear_byte_pointer, set_byte_pointer, master_clear;
  logic [1:0] dma_select;
  logic update_address, address_decrement, autoinitialize, address_hold;
  logic [7:0] read_data;
  logic read_data_enable;
  logic [15:0] current_address;
  logic terminal_count, byte_pointer;

  kf8237_address_and_count dut (
    .clock(clock), .reset_n(reset_n), .internal_data_bus(internal_data_bus),
    .write_base_and_current_address(write_base_and_current_address),
    .write_base_and_current_word_count(write_base_and_current_word_count),
    .read_current_address(read_current_address), .read_current_word_count(read_current_word_count),
    .clear_byte_pointer(clear_byte_pointer), .set_byte_pointer(set_byte_pointer),
    .master_clear(master_clear), .dma_select(dma_select), .update_address(update_address),
    .address_decrement(address_decrement), .autoinitialize(autoinitialize), .address_hold(address_hold),
    .read_data(read_data), .read_data_enable(read_data_enable), .current_address(current_address),
    .terminal_count(terminal_count), .byte_pointer(byte_pointer)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rde;
    logic [7:0] rd;
    logic [15:0] ca;
    logic tc;
    logic bp;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_ba [4], m_ca [4], m_bc [4], m_cc [4];
  logic m_bp, m_tc, m_prev;
  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  always begin
    @(negedge clock);
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("read_data_enable", 16'(read_data_enable), 16'(e.rde));
      chk("read_data", 16'(read_data), 16'(e.rd));
      chk("current_address", current_address, e.ca);
      chk("terminal_count", 16'(terminal_count), 16'(e.tc));
      chk("byte_pointer", 16'(byte_pointer), 16'(e.bp));
    end
  end

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ba[c] = 16'h0000; m_ca[c] = 16'h0000; m_bc[c] = 16'h0000; m_cc[c] = 16'h0000;
    end
    m_bp = 1'b0; m_tc = 1'b0; m_prev = 1'b0;
  endtask

  // Inputs are already applied; predict this cycle's outputs, advance the model, then wait one clock
  task automatic drive();
    exp_t e;
    int s;
    logic tc_now, any_w, any_r, hold_now;
    if (!reset_n) model_reset();
    e.rd = 8'h00;
    for (int c = 0; c < 4; c++) begin
      if (read_current_address[c]) e.rd |= m_bp ? m_ca[c][15:8] : m_ca[c][7:0];
      if (read_current_word_count[c]) e.rd |= m_bp ? m_cc[c][15:8] : m_cc[c][7:0];
    end
    any_r = |{read_current_address, read_current_word_count};
    e.rde = any_r; e.ca = m_ca[dma_select]; e.tc = m_tc; e.bp = m_bp;
    q.push_back(e);
    if (reset_n) begin
      s = int'(dma_select);
`ifdef KF8237_ADDRESS_HOLD_EN
      hold_now = address_hold && s == 0;
`else
      hold_now = 1'b0;
`endif
      tc_now = update_address && m_cc[s] == 16'h0000;
      if (update_address) begin
        if (tc_now && autoinitialize) begin
          m_ca[s] = m_ba[s]; m_cc[s] = m_bc[s];
        end else begin
          m_cc[s] = m_cc[s] - 16'd1;
          if (!hold_now) m_ca[s] = address_decrement ? m_ca[s] - 16'd1 : m_ca[s] + 16'd1;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (write_base_and_current_address[c]) begin
          if (m_bp) begin m_ba[c][15:8] = internal_data_bus; m_ca[c][15:8] = internal_data_bus; end
          else begin m_ba[c][7:0] = internal_data_bus; m_ca[c][7:0] = internal_data_bus; end
        end
        if (write_base_and_current_word_count[c]) begin
          if (m_bp) begin m_bc[c][15:8] = internal_data_bus; m_cc[c][15:8] = internal_data_bus; end
          else begin m_bc[c][7:0] = internal_data_bus; m_cc[c][7:0] = internal_data_bus; end
        end
      end
      any_w = |{write_base_and_current_address, write_base_and_current_word_count};
      m_tc = master_clear ? 1'b0 : tc_now;
      if (master_clear || clear_byte_pointer) m_bp = 1'b0;
      else if (set_byte_pointer) m_bp = 1'b1;
      else if (any_w || (m_prev && !any_r)) m_bp = ~m_bp;
      m_prev = any_r;
    end
    @(negedge clock);
    write_base_and_current_address = '0; write_base_and_current_word_count = '0;
    read_current_address = '0; read_current_word_count = '0;
    clear_byte_pointer = 0; set_byte_pointer = 0; master_clear = 0; update_address = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive();
  endtask

  task automatic wr(input bit cnt, input int ch, input logic [15:0] w);
    for (int b = 0; b < 2; b++) begin
      internal_data_bus = (b == 0) ? w[7:0] : w[15:8];
      if (cnt) write_base_and_current_word_count[ch] = 1'b1;
      else write_base_and_current_address[ch] = 1'b1;
      drive();
    end
  endtask

  task automatic rd(input bit cnt, input int ch);
    if (cnt) read_current_word_count[ch] = 1'b1;
    else read_current_address[ch] = 1'b1;
    drive();
    drive();
  endtask

  task automatic upd(input int ch, input bit dec, input bit ai);
    dma_select = 2'(ch); address_decrement = dec; autoinitialize = ai; update_address = 1'b1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; internal_data_bus = 0; dma_select = 0;
    write_base_and_current_address = '0; write_base_and_current_word_count = '0;
    read_current_address = '0; read_current_word_count = '0;
    clear_byte_pointer = 0; set_byte_pointer = 0; master_clear = 0; update_address = 0;
    address_decrement = 0; autoinitialize = 0; address_hold = 0;
    model_reset();
    @(negedge clock);
    idle(2);
    reset_n = 1;
    idle(1);
    dma_select = 2'd1;
    wr(0, 1, 16'h1234);
    rd(0, 1);
    rd(0, 1);
    wr(1, 2, 16'h0002);
    for (int i = 0; i < 3; i++) upd(2, 0, 0);
    idle(2);
    wr(0, 3, 16'h8000);
    wr(1, 3, 16'h0000);
    upd(3, 1, 1);
    idle(2);
    wr(0, 0, 16'hFFFF);
    upd(0, 0, 0);
    idle(1);
    upd(0, 1, 0);
    idle(1);
    internal_data_bus = 8'hAA; write_base_and_current_address[1] = 1'b1; drive();
    clear_byte_pointer = 1'b1; drive();
    internal_data_bus = 8'hBB; write_base_and_current_address[1] = 1'b1; drive();
    rd(0, 1);
    set_byte_pointer = 1'b1; drive();
    set_byte_pointer = 1'b1; read_current_address[1] = 1'b1; drive();
    idle(1);
    clear_byte_pointer = 1'b1; drive();
    address_hold = 1'b1;
    wr(0, 0, 16'h4000);
    wr(1, 0, 16'h0010);
    for (int i = 0; i < 3; i++) upd(0, 0, 0);
    idle(1);
    address_hold = 1'b0;
    wr(1, 2, 16'h0000);
    upd(2, 0, 0);
    reset_n = 0; drive();
    reset_n = 1; idle(2);
    for (int i = 0; i < 500; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      internal_data_bus = 8'($urandom);
      write_base_and_current_address = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      write_base_and_current_word_count = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      read_current_address = ($urandom_range(0, 4) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      read_current_word_count = (read_current_address == 0 && $urandom_range(0, 4) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      clear_byte_pointer = ($urandom_range(0, 15) == 0);
      set_byte_pointer = ($urandom_range(0, 15) == 0);
      master_clear = ($urandom_range(0, 31) == 0);
      update_address = ($urandom_range(0, 2) == 0);
      dma_select = 2'($urandom);
      address_decrement = 1'($urandom);
      autoinitialize = 1'($urandom);
      address_hold = 1'($urandom);
      drive();
    end
    reset_n = 1;
    idle(2);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
